// File: rtl/mem_bus_arbiter.sv
// Two-master (fetch / data) arbiter onto a single-outstanding request/response bus.
// Data requests win over fetch; a flush drops the in-flight response without aborting the bus cycle.
module mem_bus_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_data_ok,
    output logic        stallreq_if,
    input  logic        mem_req,
    input  logic        mem_wr,
    input  logic [3:0]  mem_be,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_data_ok,
    output logic        stallreq_mem,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic [31:0] bus_rdata,
    input  logic        bus_data_ok
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    state_t      r_state;
    logic        r_owner;
    logic        r_drop;
    logic        r_bus_req;
    logic        r_bus_wr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;

    logic        w_resp_ok;
    logic        w_if_ok;
    logic        w_mem_ok;

    // Arbitration FSM; bus_* fields are latched at grant and held until the response returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_owner     <= OWN_IF;
            r_drop      <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_wr    <= 1'b0;
            r_bus_be    <= 4'h0;
            r_bus_addr  <= 32'h0000_0000;
            r_bus_wdata <= 32'h0000_0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_drop <= 1'b0;
                    if (!flush && mem_req) begin
                        r_owner     <= OWN_MEM;
                        r_bus_wr    <= mem_wr;
                        r_bus_be    <= mem_be;
                        r_bus_addr  <= mem_addr;
                        r_bus_wdata <= mem_wdata;
                        r_bus_req   <= 1'b1;
                        r_state     <= S_ADDR;
                    end else if (!flush && if_req) begin
                        r_owner     <= OWN_IF;
                        r_bus_wr    <= 1'b0;
                        r_bus_be    <= 4'hF;
                        r_bus_addr  <= if_addr;
                        r_bus_wdata <= 32'h0000_0000;
                        r_bus_req   <= 1'b1;
                        r_state     <= S_ADDR;
                    end else begin
                        r_bus_req   <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                S_ADDR: begin
                    // The request stays on the bus even when flushed; only its response is discarded.
                    if (flush) begin
                        r_drop <= 1'b1;
                    end
                    if (bus_addr_ok) begin
                        r_bus_req <= 1'b0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bus_data_ok) begin
                        r_drop  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (flush) begin
                        r_drop  <= 1'b1;
                    end
                end
                default: begin
                    r_drop    <= 1'b0;
                    r_bus_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    // Response steering back to the owning requester.
    always_comb begin
        w_resp_ok = 1'b0;
        w_if_ok   = 1'b0;
        w_mem_ok  = 1'b0;
        if ((r_state == S_DATA) && bus_data_ok && !r_drop && !flush) begin
            w_resp_ok = 1'b1;
        end else begin
            w_resp_ok = 1'b0;
        end
        if (w_resp_ok && (r_owner == OWN_IF)) begin
            w_if_ok = 1'b1;
        end else begin
            w_if_ok = 1'b0;
        end
        if (w_resp_ok && (r_owner == OWN_MEM)) begin
            w_mem_ok = 1'b1;
        end else begin
            w_mem_ok = 1'b0;
        end
    end

    assign if_data_ok   = w_if_ok;
    assign mem_data_ok  = w_mem_ok;
    assign if_rdata     = w_if_ok  ? bus_rdata : 32'h0000_0000;
    assign mem_rdata    = w_mem_ok ? bus_rdata : 32'h0000_0000;
    assign stallreq_if  = if_req  & ~w_if_ok;
    assign stallreq_mem = mem_req & ~w_mem_ok;

    assign bus_req   = r_bus_req;
    assign bus_wr    = r_bus_wr;
    assign bus_be    = r_bus_be;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scenario bench for mem_bus_arbiter: inputs change on the falling edge, outputs are
// checked shortly after it, and every expected data_ok is queued when its request is driven.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_data_ok;
    logic        stallreq_if;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_data_ok;
    logic        stallreq_mem;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic [31:0] bus_rdata;
    logic        bus_data_ok;

    typedef struct {
        bit          is_mem;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    mem_bus_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_data_ok(if_data_ok), .stallreq_if(stallreq_if),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_data_ok(mem_data_ok),
        .stallreq_mem(stallreq_mem),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_be(bus_be), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_rdata(bus_rdata),
        .bus_data_ok(bus_data_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input bit is_mem, input logic [31:0] rdata);
        exp_t e;
        e.is_mem = is_mem;
        e.rdata  = rdata;
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        flush = 1'b0; if_req = 1'b0; if_addr = 32'h0;
        mem_req = 1'b0; mem_wr = 1'b0; mem_be = 4'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
        bus_addr_ok = 1'b0; bus_rdata = 32'h0; bus_data_ok = 1'b0;
    endtask

    // Scoreboard: every data_ok pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        #2;
        if (if_data_ok || mem_data_ok) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected got if_ok=%b mem_ok=%b want no pulse", if_data_ok, mem_data_ok);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.is_mem) begin
                    if (!(mem_data_ok === 1'b1 && if_data_ok === 1'b0 && mem_rdata === e.rdata && if_rdata === 32'h0)) begin
                        n_errors++;
                        $display("FAIL sb_mem got if_ok=%b mem_ok=%b mem_rdata=%h if_rdata=%h want mem_ok with %h",
                                 if_data_ok, mem_data_ok, mem_rdata, if_rdata, e.rdata);
                    end
                end else begin
                    if (!(if_data_ok === 1'b1 && mem_data_ok === 1'b0 && if_rdata === e.rdata && mem_rdata === 32'h0)) begin
                        n_errors++;
                        $display("FAIL sb_if got if_ok=%b mem_ok=%b if_rdata=%h mem_rdata=%h want if_ok with %h",
                                 if_data_ok, mem_data_ok, if_rdata, mem_rdata, e.rdata);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        @(negedge clk); idle_inputs(); rst = 1'b1; if_req = 1'b1;
        @(negedge clk); bus_data_ok = 1'b1; bus_rdata = 32'hFFFF_FFFF; #1;
        n_checks++; if (bus_req !== 1'b0 || if_data_ok !== 1'b0 || mem_data_ok !== 1'b0) begin
            n_errors++; $display("FAIL rst_ctrl got req=%b if_ok=%b mem_ok=%b want 0 0 0", bus_req, if_data_ok, mem_data_ok); end
        n_checks++; if ({bus_wr, bus_be, bus_addr, bus_wdata} !== 69'h0) begin
            n_errors++; $display("FAIL rst_fields got wr=%b be=%h addr=%h wdata=%h want all 0", bus_wr, bus_be, bus_addr, bus_wdata); end
        n_checks++; if (if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin
            n_errors++; $display("FAIL rst_rdata got %h %h want 0 0", if_rdata, mem_rdata); end
        n_checks++; if (stallreq_if !== 1'b1 || stallreq_mem !== 1'b0) begin
            n_errors++; $display("FAIL rst_stall got if=%b mem=%b want 1 0", stallreq_if, stallreq_mem); end
        @(negedge clk); idle_inputs(); rst = 1'b0;
    endtask

    task automatic test_zero_wait_if();
        @(negedge clk); if_req = 1'b1; if_addr = 32'hBFC0_0000; push_exp(1'b0, 32'h2401_0001); #1;
        n_checks++; if (stallreq_if !== 1'b1 || bus_req !== 1'b0) begin
            n_errors++; $display("FAIL zw_c1 got stall=%b req=%b want 1 0", stallreq_if, bus_req); end
        @(negedge clk); bus_addr_ok = 1'b1; #1;
        n_checks++; if (bus_req !== 1'b1 || bus_addr !== 32'hBFC0_0000 || bus_wr !== 1'b0 || bus_be !== 4'hF || bus_wdata !== 32'h0) begin
            n_errors++; $display("FAIL zw_c2 got req=%b addr=%h wr=%b be=%h wdata=%h want 1 bfc00000 0 f 0",
                                 bus_req, bus_addr, bus_wr, bus_be, bus_wdata); end
        n_checks++; if (stallreq_if !== 1'b1) begin
            n_errors++; $display("FAIL zw_stall_c2 got %b want 1", stallreq_if); end
        @(negedge clk); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h2401_0001; #1;
        n_checks++; if (if_data_ok !== 1'b1 || if_rdata !== 32'h2401_0001 || stallreq_if !== 1'b0) begin
            n_errors++; $display("FAIL zw_c3 got ok=%b rdata=%h stall=%b want 1 24010001 0", if_data_ok, if_rdata, stallreq_if); end
        @(negedge clk); idle_inputs(); #1;
        n_checks++; if (bus_req !== 1'b0 || if_data_ok !== 1'b0) begin
            n_errors++; $display("FAIL zw_c4 got req=%b ok=%b want 0 0", bus_req, if_data_ok); end
    endtask

    task automatic test_simultaneous();
        @(negedge clk); if_req = 1'b1; if_addr = 32'h0000_0100;
        mem_req = 1'b1; mem_wr = 1'b1; mem_be = 4'b0011; mem_addr = 32'h8000_0010; mem_wdata = 32'h0000_1234;
        push_exp(1'b1, 32'hDEAD_0001); push_exp(1'b0, 32'h0000_0055);
        @(negedge clk); bus_addr_ok = 1'b1; #1;
        n_checks++; if (bus_req !== 1'b1 || bus_wr !== 1'b1 || bus_be !== 4'b0011 || bus_addr !== 32'h8000_0010 || bus_wdata !== 32'h0000_1234) begin
            n_errors++; $display("FAIL sim_mem_grant got req=%b wr=%b be=%b addr=%h wdata=%h want 1 1 0011 80000010 1234",
                                 bus_req, bus_wr, bus_be, bus_addr, bus_wdata); end
        @(negedge clk); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_0001; #1;
        n_checks++; if (mem_data_ok !== 1'b1 || if_data_ok !== 1'b0 || stallreq_mem !== 1'b0 || stallreq_if !== 1'b1) begin
            n_errors++; $display("FAIL sim_mem_done got mem_ok=%b if_ok=%b st_mem=%b st_if=%b want 1 0 0 1",
                                 mem_data_ok, if_data_ok, stallreq_mem, stallreq_if); end
        @(negedge clk); mem_req = 1'b0; mem_wr = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0; #1;
        n_checks++; if (bus_req !== 1'b0) begin
            n_errors++; $display("FAIL sim_idle got req=%b want 0", bus_req); end
        @(negedge clk); bus_addr_ok = 1'b1; #1;
        n_checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h0000_0100 || bus_wr !== 1'b0 || bus_be !== 4'hF || bus_wdata !== 32'h0) begin
            n_errors++; $display("FAIL sim_if_grant got req=%b addr=%h wr=%b be=%h wdata=%h want 1 100 0 f 0",
                                 bus_req, bus_addr, bus_wr, bus_be, bus_wdata); end
        @(negedge clk); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0000_0055; #1;
        n_checks++; if (if_data_ok !== 1'b1) begin
            n_errors++; $display("FAIL sim_if_done got %b want 1", if_data_ok); end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_wait_states();
        int req_cycles = 0;
        int ok_cycles  = 0;
        int field_err  = 0;
        // bus_addr_ok in IDLE must be ignored: the grant still produces an ADDR phase.
        @(negedge clk); mem_req = 1'b1; mem_wr = 1'b0; mem_be = 4'hF; mem_addr = 32'h8000_1000;
        bus_addr_ok = 1'b1; push_exp(1'b1, 32'hCAFE_F00D);
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            bus_addr_ok = (k == 5) || (k == 6);
            bus_data_ok = (k == 3) || (k == 8);
            bus_rdata   = (k == 8) ? 32'hCAFE_F00D : 32'h1111_1111;
            #1;
            if (bus_req === 1'b1) req_cycles++;
            if (bus_addr !== 32'h8000_1000 || bus_wr !== 1'b0 || bus_be !== 4'hF || bus_wdata !== 32'h0) field_err++;
            if (mem_data_ok === 1'b1) ok_cycles++;
            if (k == 8) begin
                n_checks++; if (mem_data_ok !== 1'b1 || mem_rdata !== 32'hCAFE_F00D) begin
                    n_errors++; $display("FAIL ws_final got ok=%b rdata=%h want 1 cafef00d", mem_data_ok, mem_rdata); end
            end
        end
        @(negedge clk); idle_inputs(); #1;
        n_checks++; if (req_cycles != 4 || bus_req !== 1'b0) begin
            n_errors++; $display("FAIL ws_req_cycles got %0d (now %b) want 4 (now 0)", req_cycles, bus_req); end
        n_checks++; if (ok_cycles != 1) begin
            n_errors++; $display("FAIL ws_ok_count got %0d want 1", ok_cycles); end
        n_checks++; if (field_err != 0) begin
            n_errors++; $display("FAIL ws_fields got %0d unstable cycles want 0", field_err); end
    endtask

    task automatic test_flush_data();
        @(negedge clk); if_req = 1'b1; if_addr = 32'h0000_0200;
        @(negedge clk); bus_addr_ok = 1'b1;
        @(negedge clk); bus_addr_ok = 1'b0; flush = 1'b1; if_addr = 32'h0000_0040; #1;
        n_checks++; if (if_data_ok !== 1'b0) begin
            n_errors++; $display("FAIL fd_flush_cycle got %b want 0", if_data_ok); end
        @(negedge clk); flush = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0BAD_0BAD; #1;
        n_checks++; if (if_data_ok !== 1'b0 || if_rdata !== 32'h0) begin
            n_errors++; $display("FAIL fd_dropped got ok=%b rdata=%h want 0 0", if_data_ok, if_rdata); end
        @(negedge clk); bus_data_ok = 1'b0; bus_rdata = 32'h0; push_exp(1'b0, 32'h0000_0077); #1;
        n_checks++; if (bus_req !== 1'b0) begin
            n_errors++; $display("FAIL fd_idle got req=%b want 0", bus_req); end
        @(negedge clk); bus_addr_ok = 1'b1; #1;
        n_checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h0000_0040) begin
            n_errors++; $display("FAIL fd_regrant got req=%b addr=%h want 1 00000040", bus_req, bus_addr); end
        @(negedge clk); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0000_0077; #1;
        n_checks++; if (if_data_ok !== 1'b1 || if_rdata !== 32'h0000_0077) begin
            n_errors++; $display("FAIL fd_new_done got ok=%b rdata=%h want 1 77", if_data_ok, if_rdata); end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_flush_coincident();
        @(negedge clk); mem_req = 1'b1; mem_addr = 32'h8000_2000; mem_be = 4'hF;
        @(negedge clk); bus_addr_ok = 1'b1;
        @(negedge clk); bus_addr_ok = 1'b0; flush = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h1357_9BDF; #1;
        n_checks++; if (mem_data_ok !== 1'b0 || mem_rdata !== 32'h0 || stallreq_mem !== 1'b1) begin
            n_errors++; $display("FAIL fc_suppress got ok=%b rdata=%h stall=%b want 0 0 1", mem_data_ok, mem_rdata, stallreq_mem); end
        // Flush in ADDR: request must stay up, response must later be dropped.
        @(negedge clk); idle_inputs(); if_req = 1'b1; if_addr = 32'h0000_0300;
        @(negedge clk); flush = 1'b1; #1;
        n_checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h0000_0300) begin
            n_errors++; $display("FAIL fa_hold got req=%b addr=%h want 1 00000300", bus_req, bus_addr); end
        @(negedge clk); flush = 1'b0; bus_addr_ok = 1'b1; #1;
        n_checks++; if (bus_req !== 1'b1) begin
            n_errors++; $display("FAIL fa_still_req got %b want 1", bus_req); end
        @(negedge clk); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h2468_ACE0; #1;
        n_checks++; if (if_data_ok !== 1'b0) begin
            n_errors++; $display("FAIL fa_dropped got %b want 0", if_data_ok); end
        // Flush in IDLE blocks the grant; a request withdrawn before grant leaves no trace.
        @(negedge clk); bus_data_ok = 1'b0; bus_rdata = 32'h0; flush = 1'b1; if_req = 1'b1;
        @(negedge clk); flush = 1'b0; if_req = 1'b0; #1;
        n_checks++; if (bus_req !== 1'b0) begin
            n_errors++; $display("FAIL fi_no_grant got req=%b want 0", bus_req); end
        @(negedge clk); #1;
        n_checks++; if (bus_req !== 1'b0) begin
            n_errors++; $display("FAIL fi_withdrawn got req=%b want 0", bus_req); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); idle_inputs(); mem_req = 1'b1; mem_wr = 1'b1; mem_be = 4'hC; mem_addr = 32'h8000_3000; mem_wdata = 32'hA5A5_5A5A;
        @(negedge clk); #1;
        n_checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h8000_3000) begin
            n_errors++; $display("FAIL rm_addr got req=%b addr=%h want 1 80003000", bus_req, bus_addr); end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; mem_req = 1'b0; mem_wr = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h9999_9999; #1;
        n_checks++; if (bus_req !== 1'b0 || mem_data_ok !== 1'b0 || if_data_ok !== 1'b0 || mem_rdata !== 32'h0) begin
            n_errors++; $display("FAIL rm_after got req=%b mem_ok=%b if_ok=%b rdata=%h want 0 0 0 0", bus_req, mem_data_ok, if_data_ok, mem_rdata); end
        n_checks++; if ({bus_wr, bus_be, bus_addr, bus_wdata} !== 69'h0) begin
            n_errors++; $display("FAIL rm_fields got wr=%b be=%h addr=%h wdata=%h want all 0", bus_wr, bus_be, bus_addr, bus_wdata); end
        @(negedge clk); idle_inputs(); #1;
        n_checks++; if (bus_req !== 1'b0 || mem_data_ok !== 1'b0) begin
            n_errors++; $display("FAIL rm_settled got req=%b ok=%b want 0 0", bus_req, mem_data_ok); end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_zero_wait_if();
        test_simultaneous();
        test_wait_states();
        test_flush_data();
        test_flush_coincident();
        test_reset_mid();
        @(negedge clk); #3;
        n_checks++; if (exp_q.size() != 0) begin
            n_errors++; $display("FAIL sb_leftover got %0d pending want 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The block SHALL have the following ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  pipeline flush from ctrl.
- if_req  in  1  fetch read request; held with if_addr until if_data_ok.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetch read data.
- if_data_ok  out  1  one-cycle fetch completion pulse.
- stallreq_if  out  1  fetch stall request to ctrl.
- mem_req  in  1  data request; held with its fields until mem_data_ok.
- mem_wr  in  1  1 = write, 0 = read.
- mem_be  in  4  byte enables.
- mem_addr  in  32  data address.
- mem_wdata  in  32  write data.
- mem_rdata  out  32  data read data.
- mem_data_ok  out  1  one-cycle data completion pulse.
- stallreq_mem  out  1  data stall request to ctrl.
- bus_req  out  1  downstream request; held until bus_addr_ok.
- bus_wr  out  1  downstream write.
- bus_be  out  4  downstream byte enables.
- bus_addr  out  32  downstream address.
- bus_wdata  out  32  downstream write data.
- bus_addr_ok  in  1  downstream accepts the request this cycle.
- bus_rdata  in  32  downstream read data.
- bus_data_ok  in  1  downstream response valid this cycle.

Function
REQ-002 The block SHALL be an FSM with states IDLE, ADDR and DATA, a 1-bit owner register (IF/MEM) and a 1-bit drop flag.
REQ-003 The block SHALL allow at most one outstanding downstream transaction.
REQ-004 In IDLE with flush=0, mem_req=1 SHALL grant MEM (priority over IF), else if_req=1 SHALL grant IF.
- On grant: owner is set; addr/wr/be/wdata are latched into the bus_* registers (IF: wr=0, be=4'hF, wdata=0); next state is ADDR.
REQ-005 In IDLE with flush=1, no grant SHALL occur.
REQ-006 bus_req SHALL be 1 exactly when state=ADDR; bus_* fields SHALL stay constant from grant until return to IDLE.
REQ-007 ADDR SHALL go to DATA on bus_addr_ok=1 and SHALL otherwise hold.
- A request is never withdrawn in ADDR, flush included.
REQ-008 DATA SHALL go to IDLE on bus_data_ok=1 and SHALL otherwise hold.
REQ-009 Owner data_ok SHALL be combinational: 1 when state=DATA, bus_data_ok=1, owner matches, drop=0 and flush=0.
- Owner rdata SHALL equal bus_rdata in that cycle; rdata is 0 otherwise.
- The non-owner data_ok SHALL be 0.
REQ-010 Minimum latency SHALL be: grant cycle -> ADDR next cycle -> data_ok no earlier than the cycle after bus_addr_ok, i.e. 3 cycles when the bus is zero-wait.
REQ-011 Back-to-back transactions SHALL be possible: the cycle after data_ok the FSM is in IDLE and may grant again.
REQ-012 flush=1 while state is ADDR or DATA SHALL set drop.
- The transaction completes on the bus, but its response produces no data_ok.
- drop clears on the return to IDLE.
REQ-013 flush=1 coincident with bus_data_ok SHALL suppress that data_ok.
REQ-014 stallreq_if SHALL be if_req & ~if_data_ok; stallreq_mem SHALL be mem_req & ~mem_data_ok.
REQ-015 A bus_data_ok in IDLE or ADDR SHALL be ignored.
REQ-016 A bus_addr_ok outside ADDR SHALL be ignored.
REQ-017 Requests dropped by the requester before grant SHALL have no effect.

Reset
REQ-018 With rst=1 at a clock edge the block SHALL enter IDLE, with owner=IF, drop=0 and all bus_* registers 0, regardless of the current state.
REQ-019 During and after reset, bus_req, if_data_ok and mem_data_ok SHALL be 0.
- rdata outputs SHALL be 0.
- stall outputs follow REQ-014.
REQ-020 Reset mid-transaction SHALL abandon the transaction without producing data_ok.

Verification
REQ-021 Zero-wait IF read: if_req=1, if_addr=0xBFC00000, bus_addr_ok=1 and bus_data_ok=1 on first opportunity, bus_rdata=0x24010001 -> bus_req in cycle 2, if_data_ok with if_rdata=0x24010001 in cycle 3, stallreq_if high in cycles 1-2.
REQ-022 Simultaneous requests: if_req and mem_req (write, addr 0x80000010, be=4'b0011, wdata=0x1234) asserted together -> MEM granted first with bus_wr=1 and bus_be=0011, then IF granted in the cycle after mem_data_ok.
REQ-023 Wait states: bus_addr_ok delayed 3 cycles, bus_data_ok delayed 2 more -> bus_req and bus_* stable throughout, single data_ok pulse, no extra bus_req.
REQ-024 Flush in DATA: flush during an IF transaction in DATA -> no if_data_ok for that response, then the new if_addr=0x00000040 is granted afterwards.
REQ-025 Flush coincident with bus_data_ok -> no data_ok pulse.
REQ-026 Reset in ADDR with bus_req=1 -> bus_req=0 the next cycle, no data_ok, all outputs at reset values.
